// File: rtl/mure_pkg.sv
// Shared types for the trace-encoder commit path: commit entry layout,
// window sequencer states and commit port count.
package mure_pkg;

  localparam int unsigned XLEN            = 64;
  localparam int unsigned NR_COMMIT_PORTS = 2;

  typedef struct packed {
    logic [XLEN-1:0] iaddr;
    logic [31:0]     inst_data;
    logic            compressed;
    logic            exception;
    logic            interrupt;
    logic            eret;
  } commit_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    TAIL  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/te_commit_fifo.sv
// Two-write / one-read circular buffer of commit entries. Port 0 lands
// before port 1; ready_o is registered and means "two slots are free".
module te_commit_fifo
  import mure_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic          [NR_COMMIT_PORTS-1:0] push_i,
  input  commit_entry_t [NR_COMMIT_PORTS-1:0] entry_i,
  input  logic                                pop_i,
  output logic          [CW-1:0]              count_o,
  output logic                                empty_o,
  output logic                                ready_o,
  output commit_entry_t                       head_o
);

  localparam int unsigned LW = CW + 1;

  commit_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, wr1_idx;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] level;
  logic          pop;
  logic          ready_q;

  assign empty_o = (count_q == '0);
  assign pop     = pop_i && !empty_o;
  assign count_o = count_q;
  assign ready_o = ready_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A lone port-1 push takes the slot port 0 would have used.
  assign wr1_idx  = push_i[0] ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign wr_ptr_d = wr_ptr_q + AW'(push_i[0]) + AW'(push_i[1]);

  always_comb begin
    level = {1'b0, count_q} + LW'(push_i[0]) + LW'(push_i[1]);
    if (pop) level = level - LW'(1);
    if (level > LW'(DEPTH)) count_d = CW'(DEPTH);
    else                    count_d = level[CW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      ready_q  <= (LW'(DEPTH) - {1'b0, count_d}) >= LW'(2);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i[0]) mem_q[wr_ptr_q] <= entry_i[0];
    if (push_i[1]) mem_q[wr1_idx]  <= entry_i[1];
  end

endmodule

// File: rtl/te_commit_sequencer.sv
// Buffers up to two commits per cycle and presents them as a pc/cc/nc window.
// Optional idle tail drain is enabled by defining TE_SEQ_TAIL_DRAIN_EN.
module te_commit_sequencer
  import mure_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned IDLE_CYCLES = 16,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic          [NR_COMMIT_PORTS-1:0] commit_valid_i,
  input  commit_entry_t [NR_COMMIT_PORTS-1:0] commit_entry_i,
  output logic                                commit_ready_o,
  output logic                                pc_valid_o,
  output logic                                cc_valid_o,
  output logic                                nc_valid_o,
  output commit_entry_t                       pc_entry_o,
  output commit_entry_t                       cc_entry_o,
  output commit_entry_t                       nc_entry_o,
  output logic                                win_valid_o,
  input  logic                                win_ready_i,
  output seq_state_e                          state_o,
  output logic          [CW-1:0]              fifo_count_o
);

  // Handshakes: an upstream entry k is taken on a cycle with
  // commit_valid_i[k] && commit_ready_o; the window is consumed on a cycle
  // with win_valid_o && win_ready_i. Neither side may retract a presented item.

  seq_state_e    state_q, state_d;
  logic [1:0]    push;
  logic          any_push;
  logic          fifo_empty;
  commit_entry_t head;
  logic          shift, bubble;

  assign push     = commit_valid_i & {NR_COMMIT_PORTS{commit_ready_o && !flush_i}};
  assign any_push = |push;
  assign state_o  = state_q;

  te_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .entry_i (commit_entry_i),
    .pop_i   (shift),
    .count_o (fifo_count_o),
    .empty_o (fifo_empty),
    .ready_o (commit_ready_o),
    .head_o  (head)
  );

`ifdef TE_SEQ_TAIL_DRAIN_EN
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

  logic [IW-1:0] idle_q;
  logic          idle_fire;

  assign idle_fire = (state_q == RUN) && fifo_empty && !any_push
                     && (idle_q == IW'(IDLE_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      idle_q <= '0;
    end else if ((state_q != RUN) || !fifo_empty || any_push || idle_fire) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IW'(1);
    end
  end
`else
  logic [31:0] unused_idle_cycles;
  assign unused_idle_cycles = IDLE_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (shift) state_d = PRIME;
      PRIME:   if (shift) state_d = RUN;
      RUN:     if (bubble) state_d = TAIL;
      TAIL:    if (win_ready_i) state_d = fifo_empty ? EMPTY : PRIME;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_comb begin
    win_valid_o = (state_q == RUN) || (state_q == TAIL);
    shift       = !fifo_empty && (!win_valid_o || win_ready_i);
    bubble      = 1'b0;
`ifdef TE_SEQ_TAIL_DRAIN_EN
    // A bubble advances the window with an invalid nc; in TAIL nc is already
    // invalid, so a normal shift there also leaves cc empty.
    bubble = idle_fire || ((state_q == TAIL) && win_ready_i && fifo_empty);
`endif
    if (flush_i) begin
      shift  = 1'b0;
      bubble = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pc_valid_o <= 1'b0;
      cc_valid_o <= 1'b0;
      nc_valid_o <= 1'b0;
      pc_entry_o <= '0;
      cc_entry_o <= '0;
      nc_entry_o <= '0;
    end else if (shift) begin
      pc_valid_o <= cc_valid_o;
      pc_entry_o <= cc_entry_o;
      cc_valid_o <= nc_valid_o;
      cc_entry_o <= nc_entry_o;
      nc_valid_o <= 1'b1;
      nc_entry_o <= head;
    end else if (bubble) begin
      pc_valid_o <= cc_valid_o;
      pc_entry_o <= cc_entry_o;
      cc_valid_o <= nc_valid_o;
      cc_entry_o <= nc_entry_o;
      nc_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_te_commit_sequencer.sv
// Bench for te_commit_sequencer: directed scenarios plus random traffic
// checked every cycle against a queue-based window model.
module tb_te_commit_sequencer;
  import mure_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDLE  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = $bits(commit_entry_t);

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst_i, flush_i, win_ready_i;
  logic [1:0]           commit_valid_i;
  commit_entry_t [1:0]  commit_entry_i;
  logic                 commit_ready_o, win_valid_o;
  logic                 pc_valid_o, cc_valid_o, nc_valid_o;
  commit_entry_t        pc_entry_o, cc_entry_o, nc_entry_o;
  seq_state_e           state_o;
  logic [CW-1:0]        fifo_count_o;

  always #5 clk = ~clk;

  te_commit_sequencer #(.DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .commit_valid_i (commit_valid_i),
    .commit_entry_i (commit_entry_i),
    .commit_ready_o (commit_ready_o),
    .pc_valid_o     (pc_valid_o),
    .cc_valid_o     (cc_valid_o),
    .nc_valid_o     (nc_valid_o),
    .pc_entry_o     (pc_entry_o),
    .cc_entry_o     (cc_entry_o),
    .nc_entry_o     (nc_entry_o),
    .win_valid_o    (win_valid_o),
    .win_ready_i    (win_ready_i),
    .state_o        (state_o),
    .fifo_count_o   (fifo_count_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The window is three slots fed from an in-order queue of accepted commits.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_pc, m_cc, m_nc;
  bit            m_pcv, m_ccv, m_ncv;
  bit            m_ready = 1'b1;
  int            m_idle  = 0;

  always @(posedge clk) begin : model
    bit acc, empty, shift, bubble, run, fire, pushed;
    if (rst_i || flush_i) begin
      exp_q.delete();
      m_pc = '0; m_cc = '0; m_nc = '0;
      m_pcv = 0; m_ccv = 0; m_ncv = 0;
      m_ready = 1'b1;
      m_idle  = 0;
    end else begin
      acc    = m_ready;
      pushed = acc && (commit_valid_i != 2'b00);
      empty  = (exp_q.size() == 0);
      // The window is presentable exactly when cc holds an instruction.
      shift  = !empty && (!m_ccv || win_ready_i);
      bubble = 1'b0;
`ifdef TE_SEQ_TAIL_DRAIN_EN
      run    = m_ccv && m_ncv;
      fire   = run && empty && !pushed && (m_idle == IDLE);
      bubble = fire || (m_ccv && !m_ncv && win_ready_i && empty);
      m_idle = (run && empty && !pushed && !fire) ? m_idle + 1 : 0;
`else
      run  = 1'b0;
      fire = 1'b0;
`endif
      if (shift) begin
        m_pc = m_cc; m_pcv = m_ccv;
        m_cc = m_nc; m_ccv = m_ncv;
        m_nc = exp_q.pop_front(); m_ncv = 1'b1;
      end else if (bubble) begin
        m_pc = m_cc; m_pcv = m_ccv;
        m_cc = m_nc; m_ccv = m_ncv;
        m_ncv = 1'b0;
      end
      if (acc) begin
        if (commit_valid_i[0]) exp_q.push_back(commit_entry_i[0]);
        if (commit_valid_i[1]) exp_q.push_back(commit_entry_i[1]);
      end
      m_ready = (DEPTH - exp_q.size()) >= 2;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", commit_ready_o, m_ready);
      chk("count", fifo_count_o, exp_q.size());
      chk("pc_valid", pc_valid_o, m_pcv);
      chk("cc_valid", cc_valid_o, m_ccv);
      chk("nc_valid", nc_valid_o, m_ncv);
      chk("win_valid", win_valid_o, m_ccv);
      if (m_pcv) chk("pc_entry", pc_entry_o, m_pc);
      if (m_ccv) chk("cc_entry", cc_entry_o, m_cc);
      if (m_ncv) chk("nc_entry", nc_entry_o, m_nc);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic commit_entry_t mk(input logic [63:0] a);
    commit_entry_t e;
    e.iaddr      = a;
    e.inst_data  = $urandom;
    e.compressed = ($urandom_range(0, 1) == 1);
    e.exception  = ($urandom_range(0, 1) == 1);
    e.interrupt  = ($urandom_range(0, 1) == 1);
    e.eret       = ($urandom_range(0, 1) == 1);
    return e;
  endfunction

  task automatic push2(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1);
    commit_valid_i    = v;
    commit_entry_i[0] = mk(a0);
    commit_entry_i[1] = mk(a1);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; flush_i = 1'b0; win_ready_i = 1'b0;
    commit_valid_i = 2'b00; commit_entry_i = '0;
    step(2);
    chk_en = 1'b1;
    chk("rst_ready", commit_ready_o, 1);
    chk("rst_win_valid", win_valid_o, 0);
    chk("rst_nc_valid", nc_valid_o, 0);
    chk("rst_state", state_o, EMPTY);
    chk("rst_cc_entry", cc_entry_o, 0);
    rst_i = 1'b0;

    // First window appears three cycles after a dual push.
    push2(2'b11, 64'h100, 64'h104);
    win_ready_i = 1'b1;
    step(1);
    commit_valid_i = 2'b00;
    chk("lat_t1", win_valid_o, 0);
    step(1);
    chk("lat_t2", win_valid_o, 0);
    step(1);
    chk("lat_t3", win_valid_o, 1);
    chk("lat_cc", cc_entry_o.iaddr, 64'h100);
    chk("lat_nc", nc_entry_o.iaddr, 64'h104);
    chk("lat_pcv", pc_valid_o, 0);

    // Backpressure: fill the FIFO while the detector stalls.
    win_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push2(2'b11, 64'h1000 + 64'(16 * i), 64'h1008 + 64'(16 * i));
      step(1);
    end
    chk("full_ready", commit_ready_o, 0);
    chk("full_count", fifo_count_o, 8);
    push2(2'b11, 64'hbad0, 64'hbad8);
    step(2);
    chk("full_hold_count", fifo_count_o, 8);
    commit_valid_i = 2'b00;
    win_ready_i = 1'b1;
    for (int k = 0; k < 40 && fifo_count_o != 0; k++) step(1);
    chk("drain_done", fifo_count_o, 0);
    step(8);

    // Port-1-only push occupies a single slot.
    push2(2'b10, 64'hdead, 64'h200);
    step(1);
    commit_valid_i = 2'b00;
    chk("p1_count", fifo_count_o, 1);
    step(1);
    chk("p1_ncv", nc_valid_o, 1);
    chk("p1_nc", nc_entry_o.iaddr, 64'h200);

    // Flush wins over a simultaneous dual push while the window is running.
    win_ready_i = 1'b0;
    push2(2'b11, 64'h210, 64'h214);
    step(1);
    commit_valid_i = 2'b00;
    step(3);
    chk("pre_flush_run", win_valid_o, 1);
    push2(2'b11, 64'h220, 64'h224);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    commit_valid_i = 2'b00;
    chk("flush_win", win_valid_o, 0);
    chk("flush_ready", commit_ready_o, 1);
    chk("flush_state", state_o, EMPTY);
    chk("flush_count", fifo_count_o, 0);
    step(3);
    chk("flush_absent", nc_valid_o, 0);

    // Three commits then idle: the last one waits in nc.
    win_ready_i = 1'b1;
    push2(2'b11, 64'h300, 64'h304);
    step(1);
    push2(2'b01, 64'h308, 64'h0);
    step(1);
    commit_valid_i = 2'b00;
    step(2);
    chk("idle_cc", cc_entry_o.iaddr, 64'h304);
    chk("idle_nc", nc_entry_o.iaddr, 64'h308);
    win_ready_i = 1'b0;
`ifdef TE_SEQ_TAIL_DRAIN_EN
    for (int k = 0; k < 20 && nc_valid_o; k++) step(1);
    chk("tail_ncv", nc_valid_o, 0);
    chk("tail_cc", cc_entry_o.iaddr, 64'h308);
    chk("tail_win", win_valid_o, 1);
    win_ready_i = 1'b1;
    step(1);
    win_ready_i = 1'b0;
    chk("tail_empty", state_o, EMPTY);
    chk("tail_pcv", pc_valid_o, 1);
    chk("tail_pc", pc_entry_o.iaddr, 64'h308);
`else
    step(12);
    chk("hold_cc", cc_entry_o.iaddr, 64'h304);
    chk("hold_nc", nc_entry_o.iaddr, 64'h308);
    chk("hold_win", win_valid_o, 1);
`endif

    // Random traffic in three phases: normal, sparse, backpressured.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph = (i / 100) % 3;
      rst_i   = ($urandom_range(0, 499) == 0);
      flush_i = ($urandom_range(0, 149) == 0);
      if (ph == 1 && $urandom_range(0, 7) != 0) commit_valid_i = 2'b00;
      else commit_valid_i = 2'($urandom_range(0, 3));
      commit_entry_i[0] = mk({$urandom, $urandom});
      commit_entry_i[1] = mk({$urandom, $urandom});
      if (ph == 2) win_ready_i = ($urandom_range(0, 3) == 0);
      else         win_ready_i = ($urandom_range(0, 3) != 0);
      step(1);
    end
    rst_i = 1'b0; flush_i = 1'b0; commit_valid_i = 2'b00;
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
